// File: rtl/ihu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// ihu_mem_ctrl
//
// Synchronous sequencer for the IHU asynchronous byte-wide memory bus
// (512Kx8 SRAM and 256Kx8 EPROM).
//
// The CPU side issues single-byte read/write requests over req/ack. The
// controller decodes the target device, counts out the wait states for the
// nCS/nOE/nWE strobes, captures read data and owns the data-bus drive
// enable. Every output is a register.
//
// Optional build macro:
//   MEMCTL_WPROT_EN - SRAM writes to addr[18:0] <= WP_TOP are rejected
//                     with ack+err (same handling as a write to ROM).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, we, addr,    request, write select, byte address (addr[19]=1 ROM),
//   wdata             write data
//   rdata             last read data (held until the next completed read)
//   ack, err          one-cycle completion / error pulses
//   busy              high in every state except IDLE
//   mem_A, mem_Dout,  memory address, data to memory, data drive enable
//   mem_Doe
//   mem_Din           data from memory
//   sram_nCS, rom_nCS chip selects
//   mem_nOE, mem_nWE  shared output enable, SRAM write enable
// ---------------------------------------------------------------------------
module ihu_mem_ctrl #(
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WR_SETUP = 1,
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned WR_HOLD  = 1,
    parameter int unsigned TURN     = 1,
    parameter logic [18:0] WP_TOP   = 19'h00FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [18:0] mem_A,
    output logic [7:0]  mem_Dout,
    output logic        mem_Doe,
    input  logic [7:0]  mem_Din,
    output logic        sram_nCS,
    output logic        rom_nCS,
    output logic        mem_nOE,
    output logic        mem_nWE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACC,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_TURN
    } state_t;

    // Counter load values: a state lasts (load + 1) cycles.
    localparam logic [3:0] RD_LD = 4'(RD_WAIT  - 1);
    localparam logic [3:0] WS_LD = 4'(WR_SETUP - 1);
    localparam logic [3:0] WP_LD = 4'(WR_PULSE - 1);
    localparam logic [3:0] WH_LD = 4'(WR_HOLD  - 1);
    localparam logic [3:0] TN_LD = 4'(TURN     - 1);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        is_rom, is_rom_d;
    logic [7:0]  rdata_d, mem_Dout_d;
    logic [18:0] mem_A_d;
    logic        ack_d, err_d, busy_d, mem_Doe_d;
    logic        sram_nCS_d, rom_nCS_d, mem_nOE_d, mem_nWE_d;
    logic        wp_hit;

`ifdef MEMCTL_WPROT_EN
    assign wp_hit = !addr[19] && (addr[18:0] <= WP_TOP);
`else
    logic unused_wp_top;
    assign unused_wp_top = ^WP_TOP;
    assign wp_hit        = 1'b0;
`endif

    always_comb begin
        // Defaults: strobes inactive, bus released, data registers hold.
        state_d    = state;
        cnt_d      = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        is_rom_d   = is_rom;
        rdata_d    = rdata;
        mem_A_d    = mem_A;
        mem_Dout_d = mem_Dout;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        mem_Doe_d  = 1'b0;
        sram_nCS_d = 1'b1;
        rom_nCS_d  = 1'b1;
        mem_nOE_d  = 1'b1;
        mem_nWE_d  = 1'b1;

        case (state)
            ST_IDLE: begin
                cnt_d = cnt;
                if (req) begin
                    is_rom_d = addr[19];
                    // ROM is only 256K: bit 18 is forced low on ROM accesses.
                    mem_A_d  = {addr[18] & ~addr[19], addr[17:0]};
                    if (!we) begin
                        state_d    = ST_RD_ACC;
                        cnt_d      = RD_LD;
                        sram_nCS_d = addr[19];
                        rom_nCS_d  = ~addr[19];
                        mem_nOE_d  = 1'b0;
                    end else if (addr[19] || wp_hit) begin
                        // Rejected write: no strobes, straight to turnaround.
                        state_d = ST_TURN;
                        cnt_d   = TN_LD;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_WR_SETUP;
                        cnt_d      = WS_LD;
                        sram_nCS_d = 1'b0;
                        mem_Doe_d  = 1'b1;
                        mem_Dout_d = wdata;
                    end
                end
            end

            ST_RD_ACC: begin
                if (cnt == 4'd0) begin
                    rdata_d = mem_Din;
                    ack_d   = 1'b1;
                    state_d = ST_TURN;
                    cnt_d   = TN_LD;
                end else begin
                    sram_nCS_d = is_rom;
                    rom_nCS_d  = ~is_rom;
                    mem_nOE_d  = 1'b0;
                end
            end

            ST_WR_SETUP: begin
                sram_nCS_d = 1'b0;
                mem_Doe_d  = 1'b1;
                if (cnt == 4'd0) begin
                    state_d   = ST_WR_PULSE;
                    cnt_d     = WP_LD;
                    mem_nWE_d = 1'b0;
                end
            end

            ST_WR_PULSE: begin
                sram_nCS_d = 1'b0;
                mem_Doe_d  = 1'b1;
                if (cnt == 4'd0) begin
                    state_d = ST_WR_HOLD;
                    cnt_d   = WH_LD;
                end else begin
                    mem_nWE_d = 1'b0;
                end
            end

            ST_WR_HOLD: begin
                if (cnt == 4'd0) begin
                    ack_d   = 1'b1;
                    state_d = ST_TURN;
                    cnt_d   = TN_LD;
                end else begin
                    sram_nCS_d = 1'b0;
                    mem_Doe_d  = 1'b1;
                end
            end

            ST_TURN: begin
                if (cnt == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            is_rom   <= 1'b0;
            rdata    <= 8'h00;
            mem_A    <= 19'h0;
            mem_Dout <= 8'h00;
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            mem_Doe  <= 1'b0;
            sram_nCS <= 1'b1;
            rom_nCS  <= 1'b1;
            mem_nOE  <= 1'b1;
            mem_nWE  <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            is_rom   <= is_rom_d;
            rdata    <= rdata_d;
            mem_A    <= mem_A_d;
            mem_Dout <= mem_Dout_d;
            ack      <= ack_d;
            err      <= err_d;
            busy     <= busy_d;
            mem_Doe  <= mem_Doe_d;
            sram_nCS <= sram_nCS_d;
            rom_nCS  <= rom_nCS_d;
            mem_nOE  <= mem_nOE_d;
            mem_nWE  <= mem_nWE_d;
        end
    end

endmodule

// File: tb/tb_ihu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ihu_mem_ctrl
//
// Directed bench for ihu_mem_ctrl with default timing parameters. A driver
// issues accesses and pushes the expected completion (ack edge, err, rdata)
// into a scoreboard queue; a monitor pops and compares on every ack. Simple
// SRAM/EPROM models sit on the memory pins and the monitor watches the bus
// invariants and counts strobe cycles per access.
// ---------------------------------------------------------------------------
module tb_ihu_mem_ctrl;

    localparam int RD_WAIT  = 2;
    localparam int WR_SETUP = 1;
    localparam int WR_PULSE = 2;
    localparam int WR_HOLD  = 1;
    localparam int TURN     = 1;
    localparam int LAT_RD   = RD_WAIT;
    localparam int LAT_WR   = WR_SETUP + WR_PULSE + WR_HOLD;
    localparam int LAT_ERR  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [19:0] addr = 20'h0;
    logic [7:0]  wdata = 8'h0;
    logic [7:0]  rdata;
    logic        ack, err, busy;
    logic [18:0] mem_A;
    logic [7:0]  mem_Dout;
    logic        mem_Doe;
    logic [7:0]  mem_Din;
    logic        sram_nCS, rom_nCS, mem_nOE, mem_nWE;

    ihu_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .mem_A(mem_A), .mem_Dout(mem_Dout), .mem_Doe(mem_Doe), .mem_Din(mem_Din),
        .sram_nCS(sram_nCS), .rom_nCS(rom_nCS), .mem_nOE(mem_nOE), .mem_nWE(mem_nWE)
    );

    always #5 clk = ~clk;

    // Memory models
    logic [7:0] sram_m [0:(1<<19)-1];
    logic [7:0] rom_m  [0:(1<<18)-1];

    assign mem_Din = (!rom_nCS && !mem_nOE)  ? rom_m[mem_A[17:0]] :
                     (!sram_nCS && !mem_nOE) ? sram_m[mem_A] : 8'h00;

    always @(posedge clk) begin
        if (!sram_nCS && !mem_nWE) sram_m[mem_A] <= mem_Dout;
    end

    // Scoreboard
    typedef struct {
        int         ack_at;
        logic       err;
        logic [7:0] rd;
    } exp_t;
    exp_t sb_q[$];

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int inv_viol = 0;
    int n_sram, n_rom, n_oe, n_we, n_doe, first_cs, first_we;
    logic prev_doe = 1'b0, prev_noe = 1'b1;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_sram = 0; n_rom = 0; n_oe = 0; n_we = 0; n_doe = 0;
        first_cs = -1; first_we = -1;
    endtask

    // Monitor: samples 1 time unit after every rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!sram_nCS && !rom_nCS) inv_viol++;
        if (!mem_nWE && sram_nCS) inv_viol++;
        if (mem_Doe && !mem_nOE) inv_viol++;
        if (mem_Doe && !prev_doe && !mem_nOE && prev_noe) inv_viol++;
        prev_doe = mem_Doe;
        prev_noe = mem_nOE;
        if (!sram_nCS) begin
            n_sram++;
            if (first_cs < 0) first_cs = cyc;
        end
        if (!rom_nCS) n_rom++;
        if (!mem_nOE) n_oe++;
        if (mem_Doe)  n_doe++;
        if (!mem_nWE) begin
            n_we++;
            if (first_we < 0) first_we = cyc;
        end
        if (err && !ack) check("err_without_ack", 1, 0);
        if (ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_edge", cyc, e.ack_at);
                check("ack_err", int'(err), int'(e.err));
                check("ack_rdata", int'(rdata), int'(e.rd));
            end
        end
    end

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("ack_timeout", 1, 0);
            sb_q.delete();
        end
    endtask

    // Single access from IDLE; req dropped right after the accept edge.
    task automatic do_acc(input logic w, input logic [19:0] a, input logic [7:0] d,
                          input logic e_err, input int lat);
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        clr_counts();
        if (!w) last_rd = a[19] ? rom_m[a[17:0]] : sram_m[a[18:0]];
        e.ack_at = cyc + 1 + lat; e.err = e_err; e.rd = last_rd;
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        wait_drain();
        repeat (TURN + 1) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   acc;
        rom_m[18'h00010]  = 8'h3C;
        sram_m[19'h00800] = 8'h99;
        clr_counts();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sram_nCS", int'(sram_nCS), 1);
        check("rst_rom_nCS", int'(rom_nCS), 1);
        check("rst_nOE", int'(mem_nOE), 1);
        check("rst_nWE", int'(mem_nWE), 1);
        check("rst_Doe", int'(mem_Doe), 0);
        check("rst_ack_err_busy", int'({ack, err, busy}), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_mem_A", int'(mem_A), 0);
        check("rst_mem_Dout", int'(mem_Dout), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // SRAM write
        do_acc(1'b1, 20'h01234, 8'hA5, 1'b0, LAT_WR);
        check("wr_sram_ncs_cycles", n_sram, 4);
        check("wr_nwe_cycles", n_we, 2);
        check("wr_nwe_offset", first_we - first_cs, 1);
        check("wr_doe_cycles", n_doe, 4);
        check("wr_rom_oe_cycles", n_rom + n_oe, 0);
        check("wr_model_data", int'(sram_m[19'h01234]), 8'hA5);

        // ROM read
        do_acc(1'b0, 20'h80010, 8'h00, 1'b0, LAT_RD);
        check("rd_rom_ncs_cycles", n_rom, 2);
        check("rd_noe_cycles", n_oe, 2);
        check("rd_sram_doe_cycles", n_sram + n_doe, 0);

        // ROM write: rejected, no strobes, rdata unchanged
        do_acc(1'b1, 20'h80000, 8'h77, 1'b1, LAT_ERR);
        check("romwr_strobes", n_sram + n_rom + n_oe + n_we + n_doe, 0);

        // SRAM read back
        do_acc(1'b0, 20'h01234, 8'h00, 1'b0, LAT_RD);
        check("rd_sram_ncs_cycles", n_sram, 2);

        // Back-to-back with req held high: write then read of same address
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 20'h00400; wdata = 8'h5A;
        e.ack_at = cyc + 1 + LAT_WR; e.err = 1'b0; e.rd = last_rd;
        sb_q.push_back(e);
        wait_drain();
        we = 1'b0;
        acc = cyc + TURN + 1;
        last_rd = 8'h5A;
        e.ack_at = acc + LAT_RD; e.err = 1'b0; e.rd = 8'h5A;
        sb_q.push_back(e);
        while (cyc < acc) @(negedge clk);
        req = 1'b0;
        wait_drain();
        repeat (TURN + 1) @(negedge clk);

        // Reset during the 2nd WR_PULSE cycle
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 20'h02000; wdata = 8'h11;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pulse_nWE", int'(mem_nWE), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_strobes", int'({sram_nCS, rom_nCS, mem_nOE, mem_nWE}), 4'hF);
        check("rstmid_doe_busy_ack", int'({mem_Doe, busy, ack}), 0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 8'h00;
        repeat (3) @(negedge clk);

        // Post-reset read and a top-of-SRAM write/read
        do_acc(1'b0, 20'h01234, 8'h00, 1'b0, LAT_RD);
        do_acc(1'b1, 20'h7FFFF, 8'hC3, 1'b0, LAT_WR);
        do_acc(1'b0, 20'h7FFFF, 8'h00, 1'b0, LAT_RD);

`ifdef MEMCTL_WPROT_EN
        do_acc(1'b1, 20'h00800, 8'h5C, 1'b1, LAT_ERR);
        check("wp_protected_unchanged", int'(sram_m[19'h00800]), 8'h99);
        check("wp_protected_strobes", n_sram + n_we + n_doe, 0);
        do_acc(1'b1, 20'h01000, 8'h6D, 1'b0, LAT_WR);
        check("wp_open_written", int'(sram_m[19'h01000]), 8'h6D);
`else
        do_acc(1'b1, 20'h00800, 8'h5C, 1'b0, LAT_WR);
        check("nowp_written", int'(sram_m[19'h00800]), 8'h5C);
`endif

        check("bus_invariants", inv_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
